// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign-fixed at the end.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     a_raw;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div_zero;

  logic                 arith_op;
  logic                 signed_op;
  logic                 accept;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic                 div_fits;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  // Operand decode and one iteration of each algorithm
  always_comb begin
    arith_op  = ~op[2];
    signed_op = ~op[0];
    accept    = start && (state == IDLE);
    a_mag     = mag(a, signed_op);
    b_mag     = mag(b, signed_op);

    addend    = acc[0] ? opnd : {WIDTH{1'b0}};
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // Partial remainder is always below the divisor, so a carry out of the shift implies a fit
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    div_fits  = (div_shift >= {1'b0, opnd});
    div_rem   = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc[WIDTH-2:0], div_fits};

    prod_fix  = cond_neg_2w(acc, neg_q);
    quo_fix   = cond_neg_w(acc[WIDTH-1:0], neg_q);
    rem_fix   = cond_neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && arith_op) state_next = RUN;
      RUN:     if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else if (clk_enable)
      state <= state_next;
  end

  // Control and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else if (clk_enable) begin
      done <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (start) begin
            if (arith_op) begin
              cnt  <= CW'(WIDTH);
              busy <= 1'b1;
            end else if (op == 3'd4) begin
              hi <= a;
            end else if (op == 3'd5) begin
              lo <= a;
            end
          end
        end
        RUN: cnt <= cnt - CW'(1);
        FIX: begin
          busy <= 1'b0;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= a_raw;
            lo <= {WIDTH{1'b1}};
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // Working datapath; its contents are don't-care until loaded by an accepted start
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      if (accept && arith_op) begin
        is_div   <= op[1];
        a_raw    <= a;
        div_zero <= (b == '0);
        neg_q    <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r    <= signed_op && a[WIDTH-1];
        if (op[1]) begin
          acc  <= {{WIDTH{1'b0}}, a_mag};
          opnd <= b_mag;
        end else begin
          acc  <= {{WIDTH{1'b0}}, b_mag};
          opnd <= a_mag;
        end
      end else if (state == RUN) begin
        acc <= is_div ? div_next : mul_next;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed corner cases plus randomized operations
// compared with an arithmetic reference model.
module tb_mips_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         clk_enable;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: full-precision integer arithmetic, truncating division
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    rh = '0;
    rl = '0;
    case (o)
      3'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
      3'd2: begin
        if (y == 0) begin rh = x; rl = 32'hFFFFFFFF; end
        else begin rl = 32'(sx / sy); rh = 32'(sx % sy); end
      end
      3'd3: begin
        if (y == 0) begin rh = x; rl = 32'hFFFFFFFF; end
        else begin rl = x / y; rh = x % y; end
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; launches an op there and returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int stall_at, input int stall_len, input int resend_at,
                        output int lat, output int busy_cyc);
    start = 1'b1; op = o; a = x; b = y;
    lat = -1;
    busy_cyc = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (done) begin lat = n; break; end
      if (busy) busy_cyc++;
      if (n == resend_at) begin start = 1'b1; op = 3'd1; a = $urandom; b = $urandom; end
      if (n == resend_at + 1) start = 1'b0;
      if (n == stall_at) clk_enable = 1'b0;
      if (n == stall_at + stall_len) clk_enable = 1'b1;
    end
    clk_enable = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_enable = 1'b1; start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
    repeat (3) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_multu_max();
    int lat, bc;
    @(negedge clk);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -10, 0, -10, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_signed_directed();
    int lat, bc;
    @(negedge clk);
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, -10, 0, -10, lat, bc);
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_neg got %h_%h want ffffffff_fffffff1", hi, lo); end
    @(negedge clk);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, -10, 0, -10, lat, bc);
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
  endtask

  task automatic test_div_corners();
    int lat, bc;
    @(negedge clk);
    run_op(3'd3, 32'd7, 32'd0, -10, 0, -10, lat, bc);
    checks++; if ({hi, lo} !== 64'h00000007_FFFFFFFF) begin errors++; $display("FAIL divu_zero got %h_%h want 00000007_ffffffff", hi, lo); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_zero_latency got %0d want 33", lat); end
    @(negedge clk);
    run_op(3'd2, 32'hFFFFFFFB, 32'd0, -10, 0, -10, lat, bc);
    checks++; if ({hi, lo} !== 64'hFFFFFFFB_FFFFFFFF) begin errors++; $display("FAIL div_zero_neg got %h_%h want fffffffb_ffffffff", hi, lo); end
    @(negedge clk);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, -10, 0, -10, lat, bc);
    checks++; if ({hi, lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] old_hi, old_lo, v;
    @(negedge clk);
    old_lo = lo;
    start = 1'b1; op = 3'd4; a = 32'h12345678; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    checks++; if (lo !== old_lo) begin errors++; $display("FAIL mthi_lo_kept got %h want %h", lo, old_lo); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mthi_busy_done got %b want 00", {busy, done}); end
    v = $urandom;
    start = 1'b1; op = 3'd5; a = v;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({hi, lo} !== {32'h12345678, v}) begin errors++; $display("FAIL mtlo got %h_%h want 12345678_%h", hi, lo, v); end
    old_hi = hi; old_lo = lo;
    for (int o = 6; o < 8; o++) begin
      start = 1'b1; op = 3'(o); a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++; if ({busy, done, hi, lo} !== {2'b00, old_hi, old_lo}) begin
        errors++; $display("FAIL ignored_op%0d got %b%b %h_%h want 00 %h_%h", o, busy, done, hi, lo, old_hi, old_lo);
      end
    end
  endtask

  task automatic test_ignored_start_and_stall();
    int lat, bc;
    logic [31:0] x, y, eh, el;
    x = $urandom; y = $urandom;
    model(3'd1, x, y, eh, el);
    @(negedge clk);
    run_op(3'd1, x, y, -10, 0, 5, lat, bc);
    checks++; if ({hi, lo} !== {eh, el}) begin errors++; $display("FAIL busy_start_ignored got %h_%h want %h_%h", hi, lo, eh, el); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency got %0d want 33", lat); end
    x = $urandom; y = $urandom;
    model(3'd0, x, y, eh, el);
    @(negedge clk);
    run_op(3'd0, x, y, 10, 5, -10, lat, bc);
    checks++; if (lat !== 38) begin errors++; $display("FAIL stall_latency got %0d want 38", lat); end
    checks++; if (bc !== 38) begin errors++; $display("FAIL stall_busy_cycles got %0d want 38", bc); end
    checks++; if ({hi, lo} !== {eh, el}) begin errors++; $display("FAIL stall_result got %h_%h want %h_%h", hi, lo, eh, el); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [31:0] eh, el;
    model(3'd3, 32'd1000, 32'd7, eh, el);
    @(negedge clk);
    run_op(3'd3, 32'd1000, 32'd7, -10, 0, -10, lat, bc);
    checks++; if ({hi, lo} !== {eh, el}) begin errors++; $display("FAIL b2b_first got %h_%h want %h_%h", hi, lo, eh, el); end
    model(3'd0, 32'h80000000, 32'h80000000, eh, el);
    run_op(3'd0, 32'h80000000, 32'h80000000, -10, 0, -10, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    checks++; if ({hi, lo} !== {eh, el}) begin errors++; $display("FAIL b2b_second got %h_%h want %h_%h", hi, lo, eh, el); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, seen;
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'hDEADBEEF; b = 32'h01234567;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midreset_busy_done got %b want 00", {busy, done}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL midreset_hilo got %h_%h want 0_0", hi, lo); end
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
    run_op(3'd1, 32'd6, 32'd7, -10, 0, -10, lat, bc);
    checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL after_reset_mul got %h_%h want 0_2a", hi, lo); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int lat, bc;
    logic [2:0] o;
    logic [31:0] x, y, eh, el;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      x = pick(); y = pick();
      model(o, x, y, eh, el);
      @(negedge clk);
      run_op(o, x, y, ($urandom_range(0, 3) == 0) ? 20 : -10, 2, -10, lat, bc);
      checks++; if ({hi, lo} !== {eh, el}) begin
        errors++; $display("FAIL random_op%0d a=%h b=%h got %h_%h want %h_%h", o, x, y, hi, lo, eh, el);
      end
      checks++; if (lat < 0) begin errors++; $display("FAIL random_timeout op%0d got %0d want done", o, lat); end
    end
  endtask

  initial begin
    start = 1'b0; op = '0; a = '0; b = '0; clk_enable = 1'b1; reset = 1'b1;
    test_reset();
    test_multu_max();
    test_signed_directed();
    test_div_corners();
    test_mthi_mtlo();
    test_ignored_start_and_stall();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
